// File: rtl/pcm_to_i2s.sv
// pcm_to_i2s: I2S transmitter with one-pair pending buffer, MSB first, one-bit delay after ws edges
module pcm_to_i2s #(
   parameter int NUMBER_OF_BITS = 8,
   parameter int SLOT_BITS      = 16,
   parameter int HALF_PERIOD    = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [NUMBER_OF_BITS-1:0] sample_left,
   input  logic [NUMBER_OF_BITS-1:0] sample_right,
   input  logic                      sample_valid,
   output logic                      sample_ready,
   output logic                      sck,
   output logic                      ws,
   output logic                      sd,
   output logic                      frame_start,
   output logic                      underrun
);
   localparam int N  = NUMBER_OF_BITS;
   localparam int SW = $clog2(2 * SLOT_BITS);
   localparam int DW = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(HALF_PERIOD - 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(2 * SLOT_BITS - 1);
   localparam logic [SW-1:0] WS_BEG    = SW'(SLOT_BITS);
   localparam logic [SW-1:0] L_END     = SW'(N);
   localparam logic [SW-1:0] R_BEG     = SW'(SLOT_BITS + 1);
   localparam logic [SW-1:0] R_END     = SW'(SLOT_BITS + N);

   if (SLOT_BITS < NUMBER_OF_BITS + 1) begin : g_bad_slot
      $error("SLOT_BITS must be >= NUMBER_OF_BITS+1");
   end
   if (HALF_PERIOD < 1) begin : g_bad_half
      $error("HALF_PERIOD must be >= 1");
   end

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   div_q, div_d;
   logic [SW-1:0]   slot_q, slot_d, ns;
   logic            sck_q, sck_d, ws_q, ws_d, sd_q, sd_d;
   logic            fs_q, fs_d, ur_q, ur_d;
   logic            pf_q, pf_d;
   logic [N-1:0]    pl_q, pl_d, pr_q, pr_d, shl_q, shl_d, shr_q, shr_d;
   logic            accept, load, in_l, in_r;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      slot_d  = slot_q;
      sck_d   = sck_q;
      ws_d    = ws_q;
      sd_d    = sd_q;
      fs_d    = 1'b0;
      ur_d    = 1'b0;
      shl_d   = shl_q;
      shr_d   = shr_q;
      accept  = sample_valid && !pf_q;
      pf_d    = pf_q | accept;
      pl_d    = accept ? sample_left : pl_q;
      pr_d    = accept ? sample_right : pr_q;
      ns      = slot_q + 1'b1;
      in_l    = ns <= L_END;
      in_r    = ns >= R_BEG && ns <= R_END;
      load    = 1'b0;
      if (state_q == IDLE) begin
         load = enable;
      end else if (div_q == DIV_LAST) begin
         div_d = '0;
         sck_d = !sck_q;
         // falling sck edge: advance slot, or close the frame at the wrap
         if (sck_q && slot_q == SLOT_LAST) begin
            load    = enable;
            state_d = enable ? RUN : IDLE;
            slot_d  = '0;
            ws_d    = 1'b0;
            sd_d    = 1'b0;
         end else if (sck_q) begin
            slot_d = ns;
            ws_d   = ns >= WS_BEG;
            sd_d   = in_l ? shl_q[N-1] : (in_r ? shr_q[N-1] : 1'b0);
            shl_d  = in_l ? shl_q << 1 : shl_q;
            shr_d  = in_r ? shr_q << 1 : shr_q;
         end
      end else begin
         div_d = div_q + 1'b1;
      end
      if (load) begin
         state_d = RUN;
         div_d   = '0;
         slot_d  = '0;
         sck_d   = 1'b0;
         ws_d    = 1'b0;
         sd_d    = 1'b0;
         fs_d    = 1'b1;
         ur_d    = !pf_q;
         shl_d   = pf_q ? pl_q : '0;
         shr_d   = pf_q ? pr_q : '0;
         pf_d    = accept;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         slot_q  <= '0;
         sck_q   <= 1'b0;
         ws_q    <= 1'b0;
         sd_q    <= 1'b0;
         fs_q    <= 1'b0;
         ur_q    <= 1'b0;
         pf_q    <= 1'b0;
         pl_q    <= '0;
         pr_q    <= '0;
         shl_q   <= '0;
         shr_q   <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         slot_q  <= slot_d;
         sck_q   <= sck_d;
         ws_q    <= ws_d;
         sd_q    <= sd_d;
         fs_q    <= fs_d;
         ur_q    <= ur_d;
         pf_q    <= pf_d;
         pl_q    <= pl_d;
         pr_q    <= pr_d;
         shl_q   <= shl_d;
         shr_q   <= shr_d;
      end
   end

   assign sample_ready = !pf_q;
   assign sck          = sck_q;
   assign ws           = ws_q;
   assign sd           = sd_q;
   assign frame_start  = fs_q;
   assign underrun     = ur_q;
endmodule

// File: tb/tb_pcm_to_i2s.sv
// tb_pcm_to_i2s: scoreboard bench; a monitor decodes every frame against queued expected pairs
module tb_pcm_to_i2s;
   localparam int N = 8, SB = 16, HP = 2, FRAME = 4 * SB * HP;

   logic clk = 1'b0, reset = 1'b1, enable = 1'b0, sample_valid = 1'b0;
   logic [N-1:0] sample_left = '0, sample_right = '0;
   logic sample_ready, sck, ws, sd, frame_start, underrun;

   pcm_to_i2s #(.NUMBER_OF_BITS(N), .SLOT_BITS(SB), .HALF_PERIOD(HP)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .sample_left(sample_left), .sample_right(sample_right),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .sck(sck), .ws(ws), .sd(sd), .frame_start(frame_start), .underrun(underrun)
   );

   always #5 clk = !clk;

   typedef struct {logic [N-1:0] l; logic [N-1:0] r; logic ur;} exp_t;
   exp_t sbq[$];
   int n_chk = 0, n_fail = 0;
   logic active = 1'b0;
   logic [N-1:0] al[16], ar[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // monitor: frame_start pops the expected pair, then every clk of the frame is checked
   initial begin
      exp_t cur;
      int c, s, errs;
      logic [N-1:0] rl, rr;
      logic e_sck, e_ws, e_sd;
      c = 0; errs = 0; rl = '0; rr = '0;
      cur = '{l: '0, r: '0, ur: 1'b0};
      forever begin
         @(negedge clk);
         if (reset) begin
            active = 1'b0;
         end else begin
            if (frame_start) begin
               if (active) chk("frame_too_early", c, FRAME);
               if (sbq.size() == 0) begin
                  chk("unexpected_frame", 1, 0);
                  active = 1'b0;
               end else begin
                  cur = sbq.pop_front();
                  active = 1'b1;
                  c = 0; errs = 0; rl = '0; rr = '0;
                  chk("underrun_at_load", underrun, cur.ur);
               end
            end else if (active) begin
               c++;
            end
            if (active) begin
               s = c / (2 * HP);
               e_sck = (c % (2 * HP)) >= HP;
               e_ws = s >= SB;
               e_sd = (s >= 1 && s <= N) ? cur.l[N-s] : (s >= SB + 1 && s <= SB + N) ? cur.r[SB+N-s] : 1'b0;
               if (sck !== e_sck || ws !== e_ws || sd !== e_sd || (c > 0 && (frame_start || underrun))) errs++;
               if (c % (2 * HP) == HP && s >= 1 && s <= N) rl = {rl[N-2:0], sd};
               if (c % (2 * HP) == HP && s >= SB + 1 && s <= SB + N) rr = {rr[N-2:0], sd};
               if (c == FRAME - 1) begin
                  chk("left_recovered", rl, cur.l);
                  chk("right_recovered", rr, cur.r);
                  chk("frame_waveform_errors", errs, 0);
                  active = 1'b0;
               end
            end
         end
      end
   end

   task automatic offer(input logic [N-1:0] l, input logic [N-1:0] r, input logic do_push);
      int t;
      sample_left = l; sample_right = r; sample_valid = 1'b1;
      for (t = 0; t < 400 && !sample_ready; t++) @(negedge clk);
      if (!sample_ready) chk("offer_timeout", 0, 1);
      @(negedge clk);
      sample_valid = 1'b0;
      if (do_push) sbq.push_back('{l: l, r: r, ur: 1'b0});
      chk("ready_low_after_accept", sample_ready, 0);
   endtask

   task automatic wait_fs();
      int t;
      for (t = 0; t < 400 && !frame_start; t++) @(negedge clk);
      if (!frame_start) chk("frame_start_timeout", 0, 1);
   endtask

   task automatic wait_ready();
      int t;
      for (t = 0; t < 400 && !sample_ready; t++) @(negedge clk);
      chk("ready_after_load", sample_ready, 1);
   endtask

   task automatic wait_idle();
      int t, bad;
      repeat (2) @(negedge clk);
      for (t = 0; t < 400 && active; t++) @(negedge clk);
      if (active) chk("frame_end_timeout", 0, 1);
      bad = 0;
      repeat (8) begin
         @(negedge clk);
         if (sck || ws || sd || frame_start || underrun) bad++;
      end
      chk("idle_outputs_nonzero", bad, 0);
   endtask

   task automatic stream(input int n);
      for (int i = 0; i < n; i++) begin
         offer(al[i], ar[i], 1'b1);
         if (i == 0) enable = 1'b1;
         if (i > 0) begin
            repeat (40) @(negedge clk);
            chk("ready_low_until_load", sample_ready, 0);
         end
      end
      wait_ready();
      enable = 1'b0;
      wait_idle();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_sck", sck, 0);
      chk("reset_ws", ws, 0);
      chk("reset_sd", sd, 0);
      chk("reset_frame_start", frame_start, 0);
      chk("reset_underrun", underrun, 0);
      chk("reset_ready", sample_ready, 1);
      reset = 1'b0;
      @(negedge clk);
      // single underrun frame
      sbq.push_back('{l: '0, r: '0, ur: 1'b1});
      enable = 1'b1;
      wait_fs();
      chk("first_load_underrun", underrun, 1);
      enable = 1'b0;
      wait_idle();
      // pair loaded while idle
      offer(8'hA5, 8'h3C, 1'b1);
      enable = 1'b1;
      wait_fs();
      chk("pair_load_no_underrun", underrun, 0);
      enable = 1'b0;
      wait_idle();
      // back-to-back pairs
      al[0] = 8'h01; ar[0] = 8'h80;
      al[1] = 8'hFF; ar[1] = 8'h00;
      stream(2);
      // 16 random continuous frames
      for (int i = 0; i < 16; i++) begin
         al[i] = 8'($urandom);
         ar[i] = 8'($urandom);
      end
      stream(16);
      // enable dropped around s=10: frame still completes
      offer(8'h5A, 8'hC3, 1'b1);
      enable = 1'b1;
      wait_fs();
      repeat (40) @(negedge clk);
      enable = 1'b0;
      wait_idle();
      // reset around s=5 with a pair pending
      offer(8'h96, 8'h69, 1'b1);
      enable = 1'b1;
      wait_fs();
      offer(8'hE7, 8'h18, 1'b0);
      repeat (18) @(negedge clk);
      reset = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      chk("midreset_sck", sck, 0);
      chk("midreset_ws", ws, 0);
      chk("midreset_sd", sd, 0);
      chk("midreset_frame_start", frame_start, 0);
      chk("midreset_ready", sample_ready, 1);
      reset = 1'b0;
      @(negedge clk);
      sbq.push_back('{l: '0, r: '0, ur: 1'b1});
      enable = 1'b1;
      wait_fs();
      chk("post_reset_underrun", underrun, 1);
      enable = 1'b0;
      wait_idle();
      chk("scoreboard_drained", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
